// File: rtl/omux_arbiter.sv
// omux_arbiter: round-robin arbiter sharing the FT2232 transmit path between
// N_PORTS byte-stream requesters using the omux req/sel handshake. A grant is
// held for a whole packet (until the holder drops req), and the granted byte
// is forwarded to the transmit FIFO as a registered byte/write-strobe pair.
module omux_arbiter #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [N_PORTS-1:0]     req_i,
  input  logic [8*N_PORTS-1:0]   data_i,
  output logic [N_PORTS-1:0]     sel_o,
  input  logic                   tx_rdy_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_wr_o,
  output logic                   grant_valid_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic [15:0]            byte_count_o
);

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_wr_q, tx_wr_d;
  logic [15:0]      byte_count_q, byte_count_d;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  int unsigned      pos;
  logic             take;
  logic [7:0]       grant_byte;

  // Rotating-priority scan: first requesting port after last_q, wrapping at N_PORTS.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    cand   = '0;
    pos    = 0;
    for (int unsigned i = 1; i <= N_PORTS; i++) begin
      pos = 32'(last_q) + i;
      if (pos >= N_PORTS) pos = pos - N_PORTS;
      cand = IDX_W'(pos);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Consume strobe for the granted port only; forced low while reset is asserted.
  always_comb begin
    grant_byte = data_i[{grant_idx_q, 3'b000} +: 8];
    take       = (state_q == GRANT) && reset_n_i && req_i[grant_idx_q] && tx_rdy_i;
    sel_o      = '0;
    if (take) sel_o[grant_idx_q] = 1'b1;
  end

  // Next-state and registered-output logic for the IDLE/GRANT FSM.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_idx_d  = grant_idx_q;
    tx_data_d    = tx_data_q;
    tx_wr_d      = 1'b0;
    byte_count_d = byte_count_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_idx_d  = winner;
          byte_count_d = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (take) begin
          tx_data_d = grant_byte;
          tx_wr_d   = 1'b1;
          if (byte_count_q != '1) byte_count_d = byte_count_q + 16'd1;
        end
        if (!req_i[grant_idx_q]) begin
          last_d  = grant_idx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; port 0 gets first priority.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      last_q       <= IDX_W'(N_PORTS - 1);
      grant_idx_q  <= '0;
      tx_data_q    <= '0;
      tx_wr_q      <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_idx_q  <= grant_idx_d;
      tx_data_q    <= tx_data_d;
      tx_wr_q      <= tx_wr_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign tx_data_o     = tx_data_q;
  assign tx_wr_o       = tx_wr_q;
  assign grant_valid_o = (state_q == GRANT);
  assign grant_idx_o   = grant_idx_q;
  assign byte_count_o  = byte_count_q;

endmodule

// File: tb/tb_omux_arbiter.sv
// Testbench for omux_arbiter: packet-level requesters driven from queues, a
// cycle reference model of the arbitration rules, and directed scenarios.
module tb_omux_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [8*N-1:0] data;
  logic [N-1:0]  sel;
  logic          rdy;
  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          gv;
  logic [1:0]    gidx;
  logic [15:0]   bcnt;

  always #5 clk = ~clk;

  omux_arbiter #(.N_PORTS(N), .IDX_W(2)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .req_i(req), .data_i(data), .sel_o(sel),
    .tx_rdy_i(rdy), .tx_data_o(tx_data), .tx_wr_o(tx_wr), .grant_valid_o(gv),
    .grant_idx_o(gidx), .byte_count_o(bcnt)
  );

  int checks = 0;
  int failures = 0;

  // requester side
  logic [7:0] bq [N][$];
  int         lq [N][$];
  int         rem [N];

  // reference model
  bit         m_busy;
  int         m_g, m_last, m_cnt;
  bit         m_wr;
  logic [7:0] m_data;

  // observation
  logic [7:0] cap[$];
  int         gseq[$];
  int         wr_count;
  bit         prev_gv;
  int         bytes_added;

  task automatic add_pkt(input int k, input int len, input logic [7:0] b0, input bit rnd);
    logic [7:0] b;
    b = b0;
    for (int i = 0; i < len; i++) begin
      bq[k].push_back(rnd ? 8'($urandom) : b);
      b = b + 8'h11;
    end
    lq[k].push_back(len);
    bytes_added += len;
  endtask

  task automatic clear_port(input int k);
    bq[k].delete();
    lq[k].delete();
    rem[k] = 0;
  endtask

  task automatic drive_req();
    for (int k = 0; k < N; k++) begin
      req[k] = (rem[k] > 0);
      data[8*k +: 8] = (rem[k] > 0) ? bq[k][0] : 8'($urandom);
    end
  endtask

  // One clock: check sel_o before the edge, advance the model, check registered outputs after.
  task automatic cycle();
    logic [N-1:0] exp_sel, seen_sel;
    int p;
    bit chosen;
    drive_req();
    #1;
    exp_sel = '0;
    if (reset_n && m_busy && req[m_g] && rdy) exp_sel[m_g] = 1'b1;
    seen_sel = sel;
    checks++;
    if (sel !== exp_sel) begin
      failures++;
      $display("FAIL sel_o: got %b expected %b at %0t", sel, exp_sel, $time);
    end
    if (!reset_n) begin
      m_busy = 0; m_wr = 0; m_data = 8'h00; m_g = 0; m_cnt = 0; m_last = N - 1;
    end else if (!m_busy) begin
      m_wr = 0;
      chosen = 0;
      for (int k = 1; k <= N; k++) begin
        p = (m_last + k) % N;
        if (!chosen && req[p]) begin
          chosen = 1; m_busy = 1; m_g = p; m_cnt = 0;
        end
      end
    end else begin
      if (exp_sel[m_g]) begin
        m_data = data[8*m_g +: 8];
        m_wr = 1;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else begin
        m_wr = 0;
      end
      if (!req[m_g]) begin
        m_last = m_g;
        m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_wr !== m_wr) begin
      failures++;
      $display("FAIL tx_wr_o: got %b expected %b at %0t", tx_wr, m_wr, $time);
    end
    checks++;
    if (tx_data !== m_data) begin
      failures++;
      $display("FAIL tx_data_o: got %h expected %h at %0t", tx_data, m_data, $time);
    end
    checks++;
    if (gv !== m_busy) begin
      failures++;
      $display("FAIL grant_valid_o: got %b expected %b at %0t", gv, m_busy, $time);
    end
    checks++;
    if (gidx !== 2'(m_g)) begin
      failures++;
      $display("FAIL grant_idx_o: got %0d expected %0d at %0t", gidx, m_g, $time);
    end
    checks++;
    if (bcnt !== 16'(m_cnt)) begin
      failures++;
      $display("FAIL byte_count_o: got %0d expected %0d at %0t", bcnt, m_cnt, $time);
    end
    if (tx_wr === 1'b1) begin
      cap.push_back(tx_data);
      wr_count++;
    end
    if (gv === 1'b1 && !prev_gv) gseq.push_back(int'(gidx));
    prev_gv = (gv === 1'b1);
    for (int k = 0; k < N; k++) begin
      bit was;
      was = rem[k] > 0;
      if (seen_sel[k] && was) begin
        void'(bq[k].pop_front());
        rem[k]--;
      end
      if (!was && lq[k].size() > 0) rem[k] = lq[k].pop_front();
    end
  endtask

  task automatic wait_idle(input int budget);
    bit pend;
    int n;
    n = 0;
    do begin
      pend = m_busy || (gv === 1'b1);
      for (int k = 0; k < N; k++) if (rem[k] > 0 || lq[k].size() > 0) pend = 1;
      if (pend) begin
        cycle();
        n++;
      end
    end while (pend && n < budget);
    if (pend) begin
      failures++;
      $display("FAIL wait_idle: timeout got busy expected idle within %0d cycles", budget);
    end
  endtask

  task automatic clear_obs();
    cap.delete();
    gseq.delete();
    wr_count = 0;
    bytes_added = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rdy = 1'b1;
    for (int k = 0; k < N; k++) clear_port(k);
    cycle();
    cycle();
    reset_n = 1'b1;
    clear_obs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (tx_wr !== 1'b0 || tx_data !== 8'h00 || gv !== 1'b0 || gidx !== 2'd0 || bcnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: got wr=%b data=%h gv=%b idx=%0d cnt=%0d expected all zero",
               tx_wr, tx_data, gv, gidx, bcnt);
    end
  endtask

  task automatic test_single_port();
    do_reset();
    add_pkt(0, 4, 8'h11, 0);
    wait_idle(50);
    checks++;
    if (cap.size() != 4 || cap[0] !== 8'h11 || cap[1] !== 8'h22 || cap[2] !== 8'h33 || cap[3] !== 8'h44) begin
      failures++;
      $display("FAIL single_bytes: got %p expected 11 22 33 44", cap);
    end
    checks++;
    if (bcnt !== 16'd4) begin
      failures++;
      $display("FAIL single_count: got %0d expected 4", bcnt);
    end
    checks++;
    if (gv !== 1'b0) begin
      failures++;
      $display("FAIL single_release: got %b expected 0", gv);
    end
  endtask

  task automatic test_contention();
    do_reset();
    add_pkt(1, 2, 8'hAA, 0);
    add_pkt(2, 2, 8'hCC, 0);
    wait_idle(50);
    checks++;
    if (cap.size() != 4 || cap[0] !== 8'hAA || cap[1] !== 8'hBB || cap[2] !== 8'hCC || cap[3] !== 8'hDD) begin
      failures++;
      $display("FAIL contention_bytes: got %p expected AA BB CC DD", cap);
    end
    checks++;
    if (gseq.size() != 2 || gseq[0] != 1 || gseq[1] != 2) begin
      failures++;
      $display("FAIL contention_order: got %p expected 1 2", gseq);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    add_pkt(3, 1, 8'h30, 0);
    wait_idle(50);
    gseq.delete();
    add_pkt(0, 2, 8'h01, 0);
    add_pkt(3, 2, 8'h31, 0);
    add_pkt(0, 2, 8'h05, 0);
    add_pkt(3, 1, 8'h35, 0);
    wait_idle(100);
    checks++;
    if (gseq.size() < 3 || gseq[0] != 0 || gseq[1] != 3 || gseq[2] != 0) begin
      failures++;
      $display("FAIL wrap_order: got %p expected 0 3 0 ...", gseq);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] pat;
    pat = 5'b11001; // applied LSB first: 1,0,0,1,1
    do_reset();
    add_pkt(0, 3, 8'h51, 0);
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) begin
      rdy = pat[i];
      cycle();
    end
    rdy = 1'b1;
    wait_idle(50);
    checks++;
    if (cap.size() != 3 || cap[0] !== 8'h51 || cap[1] !== 8'h62 || cap[2] !== 8'h73) begin
      failures++;
      $display("FAIL bp_bytes: got %p expected 51 62 73", cap);
    end
    checks++;
    if (bcnt !== 16'd3 || wr_count != 3) begin
      failures++;
      $display("FAIL bp_count: got cnt=%0d wr=%0d expected 3 3", bcnt, wr_count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    add_pkt(0, 4, 8'h10, 0);
    n = 0;
    while (wr_count < 2 && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (wr_count != 2) begin
      failures++;
      $display("FAIL rmid_prefix: got %0d writes expected 2", wr_count);
    end
    clear_port(0);
    add_pkt(2, 2, 8'h20, 0);
    reset_n = 1'b0;
    cycle();
    checks++;
    if (tx_wr !== 1'b0 || gv !== 1'b0 || bcnt !== 16'd0) begin
      failures++;
      $display("FAIL rmid_reset: got wr=%b gv=%b cnt=%0d expected 0 0 0", tx_wr, gv, bcnt);
    end
    reset_n = 1'b1;
    cycle();
    checks++;
    if (gv !== 1'b1 || gidx !== 2'd2) begin
      failures++;
      $display("FAIL rmid_regrant: got gv=%b idx=%0d expected 1 2", gv, gidx);
    end
    wait_idle(50);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int k;
      k = $urandom_range(N - 1);
      if ($urandom_range(3) == 0 && lq[k].size() < 2) add_pkt(k, $urandom_range(5, 1), 8'h00, 1);
      rdy = ($urandom_range(3) != 0);
      cycle();
    end
    rdy = 1'b1;
    wait_idle(500);
    checks++;
    if (wr_count != bytes_added) begin
      failures++;
      $display("FAIL random_total: got %0d bytes expected %0d", wr_count, bytes_added);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] last_b;
    do_reset();
    add_pkt(1, 65540, 8'h00, 0);
    wait_idle(66000);
    last_b = 8'((65539 * 17) % 256);
    checks++;
    if (bcnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_count: got %h expected FFFF", bcnt);
    end
    checks++;
    if (wr_count != 65540 || cap.size() == 0 || cap[cap.size()-1] !== last_b) begin
      failures++;
      $display("FAIL sat_writes: got %0d writes expected 65540 ending %h", wr_count, last_b);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rdy = 1'b1;
    req = '0;
    data = '0;
    m_busy = 0; m_g = 0; m_last = N - 1; m_cnt = 0; m_wr = 0; m_data = 8'h00;
    prev_gv = 0;
    for (int k = 0; k < N; k++) rem[k] = 0;
    clear_obs();
    test_reset();
    test_single_port();
    test_contention();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
